dmem_dma: RTL

- Initiator-side engine for the 32x8 data memory: it drives the memory's addr/we/re/wdata lines and consumes its read data.
- Performs block copy (memory to memory) or block fill (constant to memory) of up to 32 bytes, started by a single-cycle request from the control unit.
- Sits between the control unit and the data memory port; the control unit stalls while busy is high.

---
 rtl/dmem_dma.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_dma.sv
// ============================================================================
// Module      : dmem_dma
// Description : Copy/fill DMA engine for the 32x8 data memory.
//               Optional macro DMEM_DMA_CSUM_EN adds a running byte checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_dma #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_DMA_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_src_ptr;
    logic [ADDR_W-1:0]   r_dst_ptr;
    logic [LEN_W-1:0]    r_remaining;
    logic [DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]   r_fill;
    logic [LEN_W-1:0]    r_count;
    logic [LEN_W-1:0]    w_len_clamped;
    logic                w_accept;

    assign w_len_clamped = (len > c_max_len) ? c_max_len : len;
    assign w_accept      = (r_state == S_IDLE) && start;
    assign count         = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs depend only on registered state/pointers; start only steers next state.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_clamped == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = mode ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                busy        = 1'b1;
                mem_re      = 1'b1;
                mem_addr    = r_src_ptr;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_dst_ptr;
                mem_wdata = r_mode ? r_fill : r_buf;
                if (r_remaining == LEN_W'(1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = r_mode ? S_WR : S_RD;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= 1'b0;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_buf       <= '0;
            r_fill      <= '0;
            r_count     <= '0;
        end else if (w_accept) begin
            r_mode      <= mode;
            r_src_ptr   <= src_addr;
            r_dst_ptr   <= dst_addr;
            r_remaining <= w_len_clamped;
            r_fill      <= fill_data;
            r_count     <= '0;
        end else if (r_state == S_RD) begin
            r_buf     <= mem_rdata;
            r_src_ptr <= r_src_ptr + ADDR_W'(1);
        end else if (r_state == S_WR) begin
            r_dst_ptr   <= r_dst_ptr + ADDR_W'(1);
            r_count     <= r_count + LEN_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

`ifdef DMEM_DMA_CSUM_EN
    logic [DATA_W-1:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (r_state == S_WR) begin
            r_csum <= r_csum + mem_wdata;
        end
    end

    assign csum = r_csum;
`endif

endmodule

`default_nettype wire
